dbus_initiator: RTL and testbench

- Data-bus initiator sitting between the memory stage and the memory-mapped peripherals (GPIO, timers, etc.).
- It takes one load/store request from the core and issues a single-cycle access strobe with address, write data and mask type.
- It then waits for the peripheral's registered ack or err, and returns extended load data plus a done/fault indication to the core.
- It is the initiator end of the same access/ack/err/rd protocol the peripherals implement as responders.

---
 rtl/dbus_initiator.sv | 233 +++++++++++++++++++++++
 tb/tb_dbus_initiator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_initiator.sv
// dbus_initiator: data-bus initiator between the memory stage and the
// memory-mapped peripherals. It accepts one load/store from the core,
// issues a single-cycle access strobe, waits for the responder's
// registered ack/err, and returns extended load data with done/fault.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   When defined, WAIT is bounded to TIMEOUT_CYCLES cycles. After that the
//   access completes with fault cause 11 (timeout).
//   When undefined, WAIT lasts until ack/err arrives.
module dbus_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // core side
  input  logic        i_req,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wd,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  // bus side
  output logic        o_addr_access,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wd,
  output logic [1:0]  o_mask_type,
  input  logic        i_ack,
  input  logic        i_err,
  input  logic [31:0] i_rd
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS   = 2'b10;
`ifdef BUS_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TMO   = 2'b11;
`endif

  // A timeout shorter than two WAIT cycles cannot be distinguished from a
  // normal registered ack, so reject such configurations at elaboration.
  if (TIMEOUT_CYCLES < 2 || CNT_W < 2) begin : g_bad_cfg
    $error("dbus_initiator: TIMEOUT_CYCLES must be >= 2");
  end

  state_t      r_state;
  // request fields needed after acceptance (load extension)
  logic        r_req_we;
  logic        r_req_unsigned;
  logic [1:0]  r_req_size;
  // registered outputs
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [1:0]  r_fault_cause;
  logic        r_addr_access;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [1:0]  r_mask_type;

  logic        w_ready;
  logic        w_accept;
  logic        w_misalign;
  logic [31:0] w_ext;

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tmo;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_tmo     = (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
`endif

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = i_req && w_ready;

  // Alignment / size legality of the incoming request.
  always_comb begin
    w_misalign = 1'b0;
    case (i_req_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = i_req_addr[0];
      2'b10:   w_misalign = |i_req_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  // Right-aligned responder data extended to 32 bits; stores return zero.
  always_comb begin
    w_ext = 32'd0;
    if (!r_req_we) begin
      case (r_req_size)
        2'b00:   w_ext = {{24{~r_req_unsigned & i_rd[7]}},  i_rd[7:0]};
        2'b01:   w_ext = {{16{~r_req_unsigned & i_rd[15]}}, i_rd[15:0]};
        2'b10:   w_ext = i_rd;
        default: w_ext = 32'd0;
      endcase
    end
  end

  // Control FSM; every output is registered so the bus sees clean levels.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_req_we       <= 1'b0;
      r_req_unsigned <= 1'b0;
      r_req_size     <= 2'b00;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_rdata        <= 32'd0;
      r_fault        <= 1'b0;
      r_fault_cause  <= CAUSE_NONE;
      r_addr_access  <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= 32'd0;
      r_wd           <= 32'd0;
      r_mask_type    <= 2'b00;
`ifdef BUS_TIMEOUT_EN
      r_cnt          <= '0;
`endif
    end else begin
      // single-cycle pulses default low; completion fields only live in DONE
      r_addr_access <= 1'b0;
      r_done        <= 1'b0;
      r_rdata       <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_cause <= CAUSE_NONE;

      case (r_state)
        S_IDLE, S_DONE: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_we        <= 1'b0;
          r_addr      <= 32'd0;
          r_wd        <= 32'd0;
          r_mask_type <= 2'b00;
          if (w_accept) begin
            r_req_we       <= i_req_we;
            r_req_unsigned <= i_req_unsigned;
            r_req_size     <= i_req_size;
            if (w_misalign) begin
              // illegal access completes immediately, never reaches the bus
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_fault       <= 1'b1;
              r_fault_cause <= CAUSE_ALIGN;
            end else begin
              r_state       <= S_REQ;
              r_busy        <= 1'b1;
              r_addr_access <= 1'b1;
              r_we          <= i_req_we;
              r_addr        <= i_req_addr;
              r_wd          <= i_req_wd;
              r_mask_type   <= i_req_size;
            end
          end
        end

        // Strobe cycle: any ack here is from a combinational responder and
        // is deliberately ignored.
        S_REQ: begin
          r_state <= S_WAIT;
          r_busy  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end

        S_WAIT: begin
          if (i_err || i_ack) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wd        <= 32'd0;
            r_mask_type <= 2'b00;
            if (i_err) begin
              // err wins over a simultaneous ack
              r_fault       <= 1'b1;
              r_fault_cause <= CAUSE_BUS;
            end else begin
              r_rdata <= w_ext;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (w_tmo) begin
            r_state       <= S_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_fault       <= 1'b1;
            r_fault_cause <= CAUSE_TMO;
            r_we          <= 1'b0;
            r_addr        <= 32'd0;
            r_wd          <= 32'd0;
            r_mask_type   <= 2'b00;
            r_cnt         <= w_cnt_nxt;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
`endif
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rdata       = r_rdata;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_fault_cause;
  assign o_addr_access = r_addr_access;
  assign o_we          = r_we;
  assign o_addr        = r_addr;
  assign o_wd          = r_wd;
  assign o_mask_type   = r_mask_type;

endmodule

// File: tb/tb_dbus_initiator.sv
// Scoreboard bench for dbus_initiator: stimulus pushes the expected
// completion (data, fault, cause, cycle) and a negedge monitor pops and
// compares on every o_done.
module tb_dbus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_we, req_uns;
  logic [31:0] req_addr, req_wd;
  logic [1:0]  req_size;
  logic        busy, done, fault, access, we;
  logic [31:0] rdata, addr, wd;
  logic [1:0]  cause, mask;
  logic        ack, err;
  logic [31:0] rd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_NONE = 3, R_REQACK = 4, R_MIS = 5;

  dbus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wd(req_wd),
    .i_req_size(req_size), .i_req_unsigned(req_uns),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_fault(fault),
    .o_fault_cause(cause),
    .o_addr_access(access), .o_we(we), .o_addr(addr), .o_wd(wd),
    .o_mask_type(mask),
    .i_ack(ack), .i_err(err), .i_rd(rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("rdata",      {32'd0, rdata}, {32'd0, mon_e.rdata});
        chk("fault",      {63'd0, fault}, {63'd0, mon_e.fault});
        chk("cause",      {62'd0, cause}, {62'd0, mon_e.cause});
        chk("done_cycle", 64'(cyc),       64'(mon_e.cyc));
        chk("busy_in_done", {63'd0, busy}, 64'd0);
      end
    end else if (fault || cause != 2'b00) begin
      chk("fault_outside_done", {61'd0, fault, cause}, 64'd0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"},   {55'd0, busy, done, fault, cause, access, we, mask}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
    chk({tag, "_addr"},  {32'd0, addr},  64'd0);
    chk({tag, "_wd"},    {32'd0, wd},    64'd0);
  endtask

  // One request; lat is the hand-computed cycle offset of o_done from the
  // cycle i_req is first presented.
  task automatic txn(input logic we_i, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic uns, input logic [31:0] rdv,
                     input int resp, input logic [31:0] erd, input logic ef,
                     input logic [1:0] ec, input int lat);
    int   c;
    exp_t e;
    @(negedge clk);
    c = cyc;
    req = 1'b1; req_we = we_i; req_addr = a; req_wd = d; req_size = sz; req_uns = uns;
    e.rdata = erd; e.fault = ef; e.cause = ec; e.cyc = c + lat;
    q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    if (resp == R_MIS) begin
      chk("no_strobe", {63'd0, access}, 64'd0);
      @(negedge clk);
      chk("no_strobe_after", {63'd0, access}, 64'd0);
    end else begin
      chk("strobe",     {63'd0, access}, 64'd1);
      chk("strobe_busy",{63'd0, busy},   64'd1);
      chk("bus_we",     {63'd0, we},     {63'd0, we_i});
      chk("bus_addr",   {32'd0, addr},   {32'd0, a});
      chk("bus_wd",     {32'd0, wd},     {32'd0, d});
      chk("bus_mask",   {62'd0, mask},   {62'd0, sz});
      if (resp == R_REQACK) begin ack = 1'b1; rd = 32'hdead_beef; end
      @(negedge clk);
      ack = 1'b0;
      chk("strobe_once", {63'd0, access}, 64'd0);
      chk("addr_hold",   {32'd0, addr},   {32'd0, a});
      chk("wd_hold",     {32'd0, wd},     {32'd0, d});
      if (resp == R_REQACK) @(negedge clk);
      if (resp == R_NONE) begin
`ifdef BUS_TIMEOUT_EN
        repeat (4) @(negedge clk);
`else
        for (int i = 0; i < 10; i++) begin
          chk("busy_waiting", {63'd0, busy}, 64'd1);
          @(negedge clk);
        end
        ack = 1'b1; rd = rdv;
        @(negedge clk);
        ack = 1'b0;
`endif
      end else begin
        ack = (resp != R_ERR);
        err = (resp == R_ERR) || (resp == R_BOTH);
        rd  = rdv;
        @(negedge clk);
        ack = 1'b0; err = 1'b0;
      end
    end
  endtask

  initial begin
    int c;
    exp_t e;
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0;
    req_size = 2'b00; req_uns = 1'b0; ack = 1'b0; err = 1'b0; rd = '0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // loads with extension
    txn(1'b0, 32'hffff_fffc, 32'h0, 2'b10, 1'b0, 32'h8001_00ff, R_ACK, 32'h8001_00ff, 1'b0, 2'b00, 3);
    txn(1'b0, 32'h0000_1003, 32'h0, 2'b00, 1'b0, 32'h0000_0080, R_ACK, 32'hffff_ff80, 1'b0, 2'b00, 3);
    txn(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b1, 32'h0000_8001, R_ACK, 32'h0000_8001, 1'b0, 2'b00, 3);
    txn(1'b0, 32'h0000_2006, 32'h0, 2'b01, 1'b0, 32'hffff_8001, R_ACK, 32'hffff_8001, 1'b0, 2'b00, 3);
    txn(1'b0, 32'h0000_3001, 32'h0, 2'b00, 1'b1, 32'h1234_56f0, R_ACK, 32'h0000_00f0, 1'b0, 2'b00, 3);
    // store returns zero data even if responder drives i_rd
    txn(1'b1, 32'h0000_4000, 32'hcafe_f00d, 2'b10, 1'b0, 32'h5555_5555, R_ACK, 32'h0, 1'b0, 2'b00, 3);
    // illegal requests
    txn(1'b1, 32'h0000_0101, 32'h0000_abcd, 2'b01, 1'b0, 32'h0, R_MIS, 32'h0, 1'b1, 2'b01, 1);
    txn(1'b0, 32'h0000_0100, 32'h0, 2'b11, 1'b0, 32'h0, R_MIS, 32'h0, 1'b1, 2'b01, 1);
    txn(1'b0, 32'h0000_0102, 32'h0, 2'b10, 1'b0, 32'h0, R_MIS, 32'h0, 1'b1, 2'b01, 1);
    // bus errors: err alone, and err together with ack
    txn(1'b0, 32'h0000_5000, 32'h0, 2'b10, 1'b0, 32'h7777_7777, R_ERR,  32'h0, 1'b1, 2'b10, 3);
    txn(1'b0, 32'h0000_5004, 32'h0, 2'b10, 1'b0, 32'h7777_7777, R_BOTH, 32'h0, 1'b1, 2'b10, 3);
    // ack during the strobe cycle is ignored
    txn(1'b0, 32'h0000_6000, 32'h0, 2'b10, 1'b0, 32'h0bad_cafe, R_REQACK, 32'h0bad_cafe, 1'b0, 2'b00, 4);
    // no response
`ifdef BUS_TIMEOUT_EN
    txn(1'b0, 32'h0000_7000, 32'h0, 2'b10, 1'b0, 32'h0, R_NONE, 32'h0, 1'b1, 2'b11, 6);
`else
    txn(1'b0, 32'h0000_7000, 32'h0, 2'b10, 1'b0, 32'h0000_1234, R_NONE, 32'h0000_1234, 1'b0, 2'b00, 13);
`endif

    // back-to-back stores with i_req held high
    @(negedge clk);
    c = cyc;
    req = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; req_wd = 32'h1111_2222;
    req_size = 2'b10; req_uns = 1'b0;
    e.rdata = 32'h0; e.fault = 1'b0; e.cause = 2'b00; e.cyc = c + 3; q.push_back(e);
    @(negedge clk);
    chk("b2b_strobe1", {63'd0, access}, 64'd1);
    chk("b2b_addr1",   {32'd0, addr},   64'h40);
    chk("b2b_wd1",     {32'd0, wd},     64'h1111_2222);
    req_addr = 32'h0000_0044; req_wd = 32'h3333_4444;
    e.cyc = c + 6; q.push_back(e);
    @(negedge clk);
    chk("b2b_held_no_strobe", {63'd0, access}, 64'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("b2b_strobe2", {63'd0, access}, 64'd1);
    chk("b2b_addr2",   {32'd0, addr},   64'h44);
    chk("b2b_wd2",     {32'd0, wd},     64'h3333_4444);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);

    // reset during WAIT abandons the access; a late ack is ignored
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_8000; req_size = 2'b10;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack = 1'b1; rd = 32'hffff_ffff;
    @(negedge clk);
    ack = 1'b0;
    chk("late_ack_busy",   {63'd0, busy},   64'd0);
    chk("late_ack_access", {63'd0, access}, 64'd0);
    @(negedge clk);
    chk("late_ack_done",   {63'd0, done},   64'd0);
    // IDLE again: a fresh load completes normally
    txn(1'b0, 32'h0000_9000, 32'h0, 2'b00, 1'b0, 32'h0000_007f, R_ACK, 32'h0000_007f, 1'b0, 2'b00, 3);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
